cpu_trace_buffer: RTL and testbench
===================================

Name: cpu_trace_buffer

Overview:
- Synthesizable, parametrised retirement-trace capture buffer attached beside the CPU core.
- Records pc, iaddr and x31 on every retired instruction into an on-chip ring buffer, stamping each entry with a cycle count.
- Supports fill-once capture and circular capture with a pc-match trigger.
- Captured entries are drained through a valid/ready readout port. This gives the same visibility that simulation monitors provide, but in hardware.

Parameters:
- XLEN, 32, width of pc, iaddr and x31 fields.
- DEPTH, 16, number of trace entries; power of two, at least 4.
- POST_TRIG, 8, entries captured after and including the trigger entry; must satisfy 1 <= POST_TRIG <= DEPTH.
- TSW, 16, timestamp width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- retire  in  1  instruction retired this cycle; qualifies pc/iaddr/x31.
- pc  in  XLEN  pc of the retiring instruction.
- iaddr  in  XLEN  instruction fetch address.
- x31  in  XLEN  current x31 value.
- arm  in  1  single-cycle pulse: clear buffer and start capture.
- mode  in  1  0 = fill-once, 1 = circular with trigger; sampled on arm.
- trig_pc  in  XLEN  trigger pc; sampled on arm.
- rd_valid  out  1  readout entry available.
- rd_ready  in  1  consumer accepts the entry.
- rd_ts  out  TSW  entry timestamp.
- rd_pc  out  XLEN  entry pc.
- rd_iaddr  out  XLEN  entry iaddr.
- rd_x31  out  XLEN  entry x31.
- count  out  $clog2(DEPTH+1)  entries held.
- state  out  2  0 IDLE, 1 CAPTURE, 2 POST, 3 DONE.
- triggered  out  1  trigger has fired since the last arm.

Behaviour:
- Reset (async, any time including mid-capture or mid-readout):
  - state=IDLE, count=0, pointers=0, timestamp=0, triggered=0.
  - rd_valid=0; rd_* data outputs = 0.
  - Storage contents are don't-care.
- Timestamp counter:
  - Cleared on arm; increments every clk while in CAPTURE or POST; wraps modulo 2^TSW.
  - An entry written in a cycle carries the pre-increment value.
- arm:
  - Accepted in any state; it always wins over every other event in the same cycle.
  - Clears count, pointers, timestamp and triggered; latches mode and trig_pc.
  - Next state is CAPTURE.
  - A retire coincident with arm is not captured.
- IDLE: retire ignored; rd_valid=0.
- CAPTURE, mode 0 (fill-once):
  - Each retire writes one entry at wr_ptr; wr_ptr and count increment.
  - The write that makes count==DEPTH also moves state to DONE in the same edge.
  - The trigger is ignored; triggered stays 0.
- CAPTURE, mode 1 (circular):
  - Each retire writes an entry.
  - If count==DEPTH, the oldest entry is overwritten: rd_ptr advances and count stays DEPTH.
  - A retire with pc==trig_pc is captured and sets triggered=1.
  - If POST_TRIG==1, next state is DONE; otherwise next state is POST with post_cnt=POST_TRIG-1.
- POST:
  - Each retire captures with the same overwrite rule and decrements post_cnt.
  - The capture taking post_cnt to 0 moves state to DONE.
  - pc matches in POST do not re-trigger.
- DONE:
  - retire ignored.
  - rd_valid = (count!=0).
  - rd_* present the oldest entry combinationally from rd_ptr (first-word fall-through, zero latency).
  - A pop occurs when rd_valid && rd_ready: rd_ptr increments and count decrements.
  - The pop taking count to 0 moves state to IDLE.
  - rd_* hold a stable value while rd_valid=1 and rd_ready=0.
- In all states other than DONE: rd_valid=0 and rd_ready is ignored.
- Pointer arithmetic:
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - count is tracked separately so that full and empty are distinguishable.
- The pc comparison is a full XLEN equality compare.

Test Plan:
(DEPTH=4, POST_TRIG=2, TSW=16)
1. Reset mid-capture: arm, 2 retires, then assert reset for 1 cycle -> state=0, count=0, rd_valid=0, triggered=0.
2. Fill-once: arm with mode=0; 5 retires with pc=0,4,8,12,16 -> DONE after the 4th retire, count=4; drain with rd_ready=1 yields pc 0,4,8,12 with ts 0..3; state returns to IDLE.
3. Circular trigger: arm with mode=1, trig_pc=0x20; retires with pc=0x0,0x4,...,0x30 -> trigger at 0x20, DONE after 0x24 is captured; drain yields 0x18,0x1C,0x20,0x24; triggered=1.
4. Backpressure: in DONE, hold rd_ready=0 for 3 cycles -> rd_valid=1 and rd_pc constant; then alternate rd_ready 1/0 -> exactly one pop per rd_ready=1 cycle.
5. arm/retire collision: arm and retire asserted together, with pc=0x40 -> the entry is not captured, count=0 next cycle; the following retire stores ts=1.
6. Re-arm during DONE with count=3 -> count=0, state=CAPTURE, rd_valid=0 next cycle.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// Retirement-trace capture buffer: records pc/iaddr/x31 with a cycle stamp into a ring,
// in fill-once or circular-with-trigger mode, and drains it through a FWFT valid/ready port.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | not capturing, nothing to read
// CAPTURE  | recording retires; circular mode watches for trig_pc
// POST     | trigger seen, recording post_cnt more entries
// DONE     | capture frozen, entries drain on rd_valid && rd_ready
module cpu_trace_buffer #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    parameter int TSW       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       retire,
    input  logic [XLEN-1:0]            pc,
    input  logic [XLEN-1:0]            iaddr,
    input  logic [XLEN-1:0]            x31,
    input  logic                       arm,
    input  logic                       mode,
    input  logic [XLEN-1:0]            trig_pc,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [TSW-1:0]             rd_ts,
    output logic [XLEN-1:0]            rd_pc,
    output logic [XLEN-1:0]            rd_iaddr,
    output logic [XLEN-1:0]            rd_x31,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [1:0]                 state,
    output logic                       triggered
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(POST_TRIG+1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_POST    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [TSW-1:0]  ts_q;
    logic [PW-1:0]   post_q;
    logic            trig_q;
    logic            mode_q;
    logic [XLEN-1:0] trig_pc_q;

    logic [TSW-1:0]  mem_ts    [DEPTH];
    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [XLEN-1:0] mem_iaddr [DEPTH];
    logic [XLEN-1:0] mem_x31   [DEPTH];

    logic capturing, wr_en, full, hit, pop;

    assign capturing = (state_q == S_CAPTURE) || (state_q == S_POST);
    assign wr_en     = capturing && retire && !arm;
    assign full      = (count_q == CW'(DEPTH));
    assign hit       = wr_en && (state_q == S_CAPTURE) && mode_q && (pc == trig_pc_q);
    // arm outranks a coincident pop: the buffer is cleared instead
    assign pop       = rd_valid && rd_ready && !arm;

    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = S_CAPTURE;
        end else begin
            case (state_q)
                S_CAPTURE: begin
                    if (wr_en && !mode_q && (count_q == CW'(DEPTH-1)))
                        state_d = S_DONE;
                    else if (hit)
                        state_d = (POST_TRIG == 1) ? S_DONE : S_POST;
                end
                S_POST:  if (wr_en && (post_q == PW'(1))) state_d = S_DONE;
                S_DONE:  if (pop && (count_q == CW'(1))) state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ts_q      <= '0;
            post_q    <= '0;
            trig_q    <= 1'b0;
            mode_q    <= 1'b0;
            trig_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (arm) begin
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                count_q   <= '0;
                ts_q      <= '0;
                post_q    <= '0;
                trig_q    <= 1'b0;
                mode_q    <= mode;
                trig_pc_q <= trig_pc;
            end else begin
                if (capturing)
                    ts_q <= ts_q + TSW'(1);
                if (wr_en) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                    // full ring in circular mode: drop the oldest entry
                    if (full)
                        rd_ptr_q <= rd_ptr_q + AW'(1);
                    else
                        count_q <= count_q + CW'(1);
                end
                if (hit) begin
                    trig_q <= 1'b1;
                    post_q <= PW'(POST_TRIG-1);
                end
                if (wr_en && (state_q == S_POST))
                    post_q <= post_q - PW'(1);
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                    count_q  <= count_q - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_ts[wr_ptr_q]    <= ts_q;
            mem_pc[wr_ptr_q]    <= pc;
            mem_iaddr[wr_ptr_q] <= iaddr;
            mem_x31[wr_ptr_q]   <= x31;
        end
    end

    assign rd_valid  = (state_q == S_DONE) && (count_q != '0);
    assign rd_ts     = rd_valid ? mem_ts[rd_ptr_q]    : '0;
    assign rd_pc     = rd_valid ? mem_pc[rd_ptr_q]    : '0;
    assign rd_iaddr  = rd_valid ? mem_iaddr[rd_ptr_q] : '0;
    assign rd_x31    = rd_valid ? mem_x31[rd_ptr_q]   : '0;
    assign count     = count_q;
    assign state     = state_q;
    assign triggered = trig_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer: a queue-based model predicts captured entries,
// a monitor compares every accepted readout against the predicted stream.
module tb_cpu_trace_buffer;

    localparam int XLEN      = 32;
    localparam int DEPTH     = 4;
    localparam int POST_TRIG = 2;
    localparam int TSW       = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             retire = 1'b0;
    logic [XLEN-1:0]  pc = '0, iaddr = '0, x31 = '0, trig_pc = '0;
    logic             arm = 1'b0, mode = 1'b0, rd_ready = 1'b0;
    logic             rd_valid, triggered;
    logic [TSW-1:0]   rd_ts;
    logic [XLEN-1:0]  rd_pc, rd_iaddr, rd_x31;
    logic [2:0]       count;
    logic [1:0]       state;

    cpu_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .TSW(TSW)) dut (
        .clk(clk), .reset(reset), .retire(retire), .pc(pc), .iaddr(iaddr), .x31(x31),
        .arm(arm), .mode(mode), .trig_pc(trig_pc), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_ts(rd_ts), .rd_pc(rd_pc), .rd_iaddr(rd_iaddr), .rd_x31(rd_x31),
        .count(count), .state(state), .triggered(triggered)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TSW-1:0]  ts;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] iaddr;
        logic [XLEN-1:0] x31;
    } ent_t;

    ent_t mq[$];
    ent_t expq[$];
    int   mst, mpost, mts;
    bit   mmode, mtrig;
    logic [XLEN-1:0] mtp;
    int   tests = 0, fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        expq.delete();
        mst = 0; mpost = 0; mts = 0; mmode = 0; mtrig = 0; mtp = '0;
    endtask

    // one clock edge of the reference behaviour, using the inputs now driven
    task automatic model_edge();
        ent_t e;
        if (arm) begin
            mq.delete();
            mts = 0; mtrig = 0; mmode = mode; mtp = trig_pc; mst = 1;
        end else if (mst == 1 || mst == 2) begin
            if (retire) begin
                e.ts = mts[TSW-1:0]; e.pc = pc; e.iaddr = iaddr; e.x31 = x31;
                if (mq.size() == DEPTH) void'(mq.pop_front());
                mq.push_back(e);
                if (mst == 1) begin
                    if (!mmode) begin
                        if (mq.size() == DEPTH) mst = 3;
                    end else if (pc == mtp) begin
                        mtrig = 1;
                        if (POST_TRIG == 1) mst = 3;
                        else begin mst = 2; mpost = POST_TRIG - 1; end
                    end
                end else begin
                    mpost--;
                    if (mpost == 0) mst = 3;
                end
            end
            mts = (mts + 1) % (1 << TSW);
        end else if (mst == 3) begin
            if (rd_ready && mq.size() > 0) begin
                expq.push_back(mq.pop_front());
                if (mq.size() == 0) mst = 0;
            end
        end
    endtask

    task automatic check_regs();
        chk("state", state, mst);
        chk("count", count, mq.size());
        chk("triggered", triggered, mtrig);
        chk("rd_valid", rd_valid, (mst == 3) && (mq.size() > 0));
        if (mst == 3 && mq.size() > 0) begin
            chk("rd_pc_head", rd_pc, mq[0].pc);
            chk("rd_ts_head", rd_ts, mq[0].ts);
        end
    endtask

    task automatic step(input bit a, input bit m, input logic [XLEN-1:0] tp,
                        input bit r, input logic [XLEN-1:0] p, input bit rdy);
        @(negedge clk);
        check_regs();
        arm = a; mode = m; trig_pc = tp; retire = r; pc = p;
        iaddr = $urandom; x31 = $urandom; rd_ready = rdy;
        model_edge();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; arm = 0; retire = 0; rd_ready = 0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : monitor
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && rd_valid && rd_ready && !arm) begin
                if (expq.size() == 0) begin
                    chk("unexpected_pop", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("pop_ts", rd_ts, e.ts);
                    chk("pop_pc", rd_pc, e.pc);
                    chk("pop_iaddr", rd_iaddr, e.iaddr);
                    chk("pop_x31", rd_x31, e.x31);
                end
            end
        end
    end

    initial begin : stim
        bit rm;
        model_reset();
        do_reset();

        // reset in the middle of a capture
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0, 0);
        step(0, 0, 0, 1, 32'h4, 0);
        do_reset();
        step(0, 0, 0, 0, 0, 0);
        chk("rd_pc_after_reset", rd_pc, 0);
        chk("rd_ts_after_reset", rd_ts, 0);

        // fill-once, fifth retire ignored, full drain
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 32'(i * 4), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);

        // circular with trigger at 0x20
        step(1, 1, 32'h20, 0, 0, 0);
        for (int i = 0; i <= 12; i++) step(0, 0, 0, 1, 32'(i * 4), 0);
        // backpressure, one pop, then re-arm from DONE with three entries left
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // arm with coincident retire, then capture and alternate ready
        step(1, 0, 0, 1, 32'h40, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 32'(32'h44 + i * 4), 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, bit'(i % 2));

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                rm = bit'($urandom_range(0, 1));
                step(($urandom_range(0, 39) == 0), rm, 32'($urandom_range(0, 7) * 4),
                     ($urandom_range(0, 9) < 7), 32'($urandom_range(0, 7) * 4),
                     ($urandom_range(0, 9) < 6));
            end
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        chk("expected_pops_drained", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
